// File: rtl/msg_extractor_arbiter_if.sv
// Bundles the per-port Avalon-ST sources, the shared extractor-facing stream and arbiter status.
// The master modport is the arbiter's view; the slave modport is the sources/extractor side.
interface msg_extractor_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int CHAN_W    = 2
);
  logic [NUM_PORTS-1:0]     src_valid;
  logic [NUM_PORTS-1:0]     src_startofpacket;
  logic [NUM_PORTS-1:0]     src_endofpacket;
  logic [NUM_PORTS-1:0]     src_error;
  logic [64*NUM_PORTS-1:0]  src_data;
  logic [3*NUM_PORTS-1:0]   src_empty;
  logic [NUM_PORTS-1:0]     src_ready;

  logic                     out_valid;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic                     out_error;
  logic [63:0]              out_data;
  logic [2:0]               out_empty;
  logic                     out_ready;

  logic [CHAN_W-1:0]        out_channel;
  logic                     busy;
  logic                     timeout_pulse;
  logic [15:0]              drop_count;

  modport master (
    input  src_valid, src_startofpacket, src_endofpacket, src_error, src_data, src_empty,
    output src_ready,
    output out_valid, out_startofpacket, out_endofpacket, out_error, out_data, out_empty,
    input  out_ready,
    output out_channel, busy, timeout_pulse, drop_count
  );

  modport slave (
    output src_valid, src_startofpacket, src_endofpacket, src_error, src_data, src_empty,
    input  src_ready,
    input  out_valid, out_startofpacket, out_endofpacket, out_error, out_data, out_empty,
    output out_ready,
    input  out_channel, busy, timeout_pulse, drop_count
  );
endinterface

// File: rtl/msg_extractor_arbiter.sv
// Packet-level round-robin arbiter feeding one extractor; 1-cycle grant, then zero-latency pass-through.
// Backpressure passes straight to the granted source; stalled packets are aborted with an error EOP.
module msg_extractor_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int CHAN_W    = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  msg_extractor_arbiter_if.master bus
);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [CHAN_W-1:0] LAST_PORT = CHAN_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t              state, state_nxt;
  logic [CHAN_W-1:0]   grant, grant_nxt;
  logic [CHAN_W-1:0]   last_grant, last_grant_nxt;
  logic [CHAN_W-1:0]   cand;
  logic [NUM_PORTS-1:0] flush, flush_nxt, flush_set;
  logic [NUM_PORTS-1:0] eligible, drop;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [15:0]         drop_count_q;
  logic [16:0]         drop_sum;
  logic                pulse_q;
  logic                found;
  logic                vld_g;

  logic [63:0] src_data_a  [NUM_PORTS];
  logic [2:0]  src_empty_a [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign src_data_a[i]  = bus.src_data[64*i +: 64];
    assign src_empty_a[i] = bus.src_empty[3*i +: 3];
  end

  assign eligible = bus.src_valid & bus.src_startofpacket & ~flush;
  assign vld_g    = bus.src_valid[grant];

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    flush_set      = '0;
    found          = 1'b0;
    cand           = '0;

    bus.out_valid         = 1'b0;
    bus.out_startofpacket = 1'b0;
    bus.out_endofpacket   = 1'b0;
    bus.out_error         = 1'b0;
    bus.out_data          = '0;
    bus.out_empty         = '0;
    bus.src_ready         = '0;

    case (state)
      IDLE: begin
        // Flushing ports and stray (non-SOP) beats are sunk while nothing is granted.
        bus.src_ready = flush | (bus.src_valid & ~bus.src_startofpacket);
        for (int k = 1; k <= NUM_PORTS; k++) begin
          cand = CHAN_W'((int'(last_grant) + k) % NUM_PORTS);
          if (!found && eligible[cand]) begin
            found     = 1'b1;
            grant_nxt = cand;
          end
        end
        if (found) state_nxt = BUSY;
      end

      BUSY: begin
        bus.out_valid         = vld_g;
        bus.out_startofpacket = bus.src_startofpacket[grant];
        bus.out_endofpacket   = bus.src_endofpacket[grant];
        bus.out_error         = bus.src_error[grant];
        bus.out_data          = src_data_a[grant];
        bus.out_empty         = src_empty_a[grant];
        bus.src_ready         = flush;
        bus.src_ready[grant]  = bus.out_ready;
        if (vld_g && bus.out_ready) begin
          timer_nxt = '0;
          if (bus.src_endofpacket[grant]) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end else if (!vld_g) begin
          if (timer == TMR_W'(TIMEOUT - 1)) state_nxt = ABORT;
          else                              timer_nxt = timer + 1'b1;
        end
      end

      default: begin
        bus.out_valid         = 1'b1;
        bus.out_endofpacket   = 1'b1;
        bus.out_error         = 1'b1;
        bus.src_ready         = flush;
        bus.src_ready[grant]  = 1'b0;
        if (bus.out_ready) begin
          flush_set[grant] = 1'b1;
          last_grant_nxt   = grant;
          timer_nxt        = '0;
          state_nxt        = IDLE;
        end
      end
    endcase

    drop = bus.src_valid & bus.src_ready;
    if (state == BUSY) drop[grant] = 1'b0;

    // A flushing port leaves flush once the tail (EOP) of the abandoned packet is sunk.
    flush_nxt = (flush & ~(drop & bus.src_endofpacket)) | flush_set;

    drop_sum = {1'b0, drop_count_q};
    for (int i = 0; i < NUM_PORTS; i++) begin
      drop_sum = drop_sum + 17'(drop[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= LAST_PORT;
      flush        <= '0;
      timer        <= '0;
      drop_count_q <= '0;
      pulse_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      last_grant   <= last_grant_nxt;
      flush        <= flush_nxt;
      timer        <= timer_nxt;
      drop_count_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      pulse_q      <= (state == ABORT) && bus.out_ready;
    end
  end

  assign bus.out_channel   = grant;
  assign bus.busy          = (state != IDLE);
  assign bus.timeout_pulse = pulse_q;
  assign bus.drop_count    = drop_count_q;
endmodule

// File: tb/tb_msg_extractor_arbiter.sv
// Random packet sources against a cycle-level reference model of the arbitration rules.
module tb_msg_extractor_arbiter;
  localparam int NP = 4;
  localparam int CW = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  msg_extractor_arbiter_if #(.NUM_PORTS(NP), .CHAN_W(CW)) bus ();

  msg_extractor_arbiter #(.NUM_PORTS(NP), .CHAN_W(CW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus knobs
  logic [NP-1:0] port_en;
  int vld_pct, rdy_pct, stray_pct, stall_pct, fixed_len;
  bit stray_only;

  // source driver state
  logic [NP-1:0] d_vld, d_sop, d_eop, d_err;
  logic [63:0]   d_data  [NP];
  logic [2:0]    d_empty [NP];
  int            pkt_left [NP];
  int            stall    [NP];

  // reference model: mode 0 = nothing granted, 1 = streaming a packet, 2 = presenting abort beat
  int            m_mode, m_last, m_chan, m_timer, m_drops;
  logic [NP-1:0] m_flush;
  bit            m_pulse;

  int n_pulse, n_fwd;
  int grant_log [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom % 100) < p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_last = NP - 1; m_chan = 0; m_timer = 0; m_drops = 0;
    m_flush = '0; m_pulse = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      bus.src_valid[i]           = d_vld[i];
      bus.src_startofpacket[i]   = d_sop[i];
      bus.src_endofpacket[i]     = d_eop[i];
      bus.src_error[i]           = d_err[i];
      bus.src_data[64*i +: 64]   = d_data[i];
      bus.src_empty[3*i +: 3]    = d_empty[i];
    end
    bus.out_ready = pct(rdy_pct);
  endtask

  task automatic driver_clear();
    d_vld = '0; d_sop = '0; d_eop = '0; d_err = '0;
    for (int i = 0; i < NP; i++) begin
      d_data[i] = '0; d_empty[i] = '0; pkt_left[i] = 0; stall[i] = 0;
    end
    drive();
    bus.out_ready = 1'b0;
  endtask

  task automatic gen_beat(input int i);
    if (pkt_left[i] == 0 && (stray_only || pct(stray_pct))) begin
      d_sop[i] = 1'b0;
      d_eop[i] = 1'($urandom & 1);
    end else begin
      if (pkt_left[i] == 0) begin
        pkt_left[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
        d_sop[i] = 1'b1;
      end else begin
        d_sop[i] = 1'b0;
      end
      d_eop[i] = (pkt_left[i] == 1);
      pkt_left[i]--;
    end
    d_data[i]  = {$urandom, $urandom};
    d_err[i]   = (($urandom % 8) == 0);
    d_empty[i] = 3'($urandom % 8);
    d_vld[i]   = 1'b1;
  endtask

  task automatic driver_step(input logic [NP-1:0] acc);
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) d_vld[i] = 1'b0;
      if (!d_vld[i] && port_en[i]) begin
        if (stall[i] > 0)                           stall[i]--;
        else if (pkt_left[i] > 0 && pct(stall_pct)) stall[i] = int'($urandom_range(10, 25));
        else if (pct(vld_pct))                      gen_beat(i);
      end
    end
    drive();
  endtask

  task automatic run_cycle();
    logic [NP-1:0] v, s, e, f, r_exp, drops, acc;
    logic ov, osop, oeop, oerr, rdy, found;
    logic [63:0] od;
    logic [2:0] oe;
    int g, nd, p;
    @(negedge clk);
    v = bus.src_valid; s = bus.src_startofpacket; e = bus.src_endofpacket;
    rdy = bus.out_ready; g = m_chan; f = m_flush;
    ov = 0; osop = 0; oeop = 0; oerr = 0; od = '0; oe = '0; r_exp = '0;
    case (m_mode)
      0: r_exp = f | (v & ~s);
      1: begin
        ov = v[g]; osop = s[g]; oeop = e[g]; oerr = bus.src_error[g];
        od = bus.src_data[64*g +: 64]; oe = bus.src_empty[3*g +: 3];
        r_exp = f; r_exp[g] = rdy;
      end
      default: begin
        ov = 1; oeop = 1; oerr = 1;
        r_exp = f; r_exp[g] = 1'b0;
      end
    endcase
    drops = v & r_exp;
    if (m_mode == 1) drops[g] = 1'b0;

    chk("out_valid", 64'(bus.out_valid), 64'(ov));
    if (ov) begin
      chk("out_sop",   64'(bus.out_startofpacket), 64'(osop));
      chk("out_eop",   64'(bus.out_endofpacket),   64'(oeop));
      chk("out_error", 64'(bus.out_error),         64'(oerr));
      chk("out_data",  bus.out_data,               od);
      chk("out_empty", 64'(bus.out_empty),         64'(oe));
    end
    chk("src_ready",     64'(bus.src_ready),     64'(r_exp));
    chk("busy",          64'(bus.busy),          64'(m_mode != 0));
    chk("out_channel",   64'(bus.out_channel),   64'(m_chan));
    chk("timeout_pulse", 64'(bus.timeout_pulse), 64'(m_pulse));
    chk("drop_count",    64'(bus.drop_count),    64'(m_drops));

    if (bus.timeout_pulse) n_pulse++;
    if (bus.out_valid && rdy) n_fwd++;
    if (bus.out_valid && rdy && bus.out_startofpacket) grant_log.push_back(int'(bus.out_channel));
    acc = v & bus.src_ready;

    nd = 0;
    for (int i = 0; i < NP; i++) nd += int'(drops[i]);
    m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
    m_pulse = (m_mode == 2) && rdy;
    m_flush = f & ~(drops & e);
    case (m_mode)
      0: begin
        found = 0;
        for (int k = 1; k <= NP; k++) begin
          p = (m_last + k) % NP;
          if (!found && v[p] && s[p] && !f[p]) begin
            found = 1; m_chan = p; m_mode = 1;
          end
        end
      end
      1: begin
        if (v[g] && rdy) begin
          m_timer = 0;
          if (e[g]) begin m_mode = 0; m_last = g; end
        end else if (!v[g]) begin
          if (m_timer == TO - 1) m_mode = 2;
          else                   m_timer++;
        end
      end
      default: begin
        if (rdy) begin
          m_flush[g] = 1'b1; m_last = g; m_mode = 0; m_timer = 0;
        end
      end
    endcase

    @(posedge clk);
    #1;
    driver_step(acc);
  endtask

  task automatic set_knobs(input logic [NP-1:0] en, input int len, input int vp, input int rp,
                           input int sp, input int stp, input bit so);
    port_en = en; fixed_len = len; vld_pct = vp; rdy_pct = rp;
    stray_pct = sp; stall_pct = stp; stray_only = so;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    logic [NP-1:0] exp_r;
    set_knobs('0, 0, 0, 0, 0, 0, 1'b0);
    n_pulse = 0; n_fwd = 0;
    driver_clear();
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid",     64'(bus.out_valid),     64'(0));
    chk("rst_busy",          64'(bus.busy),          64'(0));
    chk("rst_src_ready",     64'(bus.src_ready),     64'(0));
    chk("rst_out_channel",   64'(bus.out_channel),   64'(0));
    chk("rst_drop_count",    64'(bus.drop_count),    64'(0));
    chk("rst_timeout_pulse", 64'(bus.timeout_pulse), 64'(0));
    reset_n = 1'b1;

    // ports 0 and 2 raise SOP together: port 0 must win first
    set_knobs(4'b0101, 3, 100, 100, 0, 0, 1'b0);
    repeat (20) run_cycle();
    chk("first_grant",  64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));
    chk("second_grant", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'(2));

    // all ports streaming single-beat packets: strict rotation, one beat every 2 cycles
    set_knobs(4'b1111, 1, 100, 100, 0, 0, 1'b0);
    repeat (15) run_cycle();
    grant_log.delete();
    n_fwd = 0;
    repeat (20) run_cycle();
    chk("rr_throughput", 64'(n_fwd), 64'(10));
    for (int k = 1; k < grant_log.size(); k++)
      chk("rr_order", 64'(grant_log[k]), 64'((grant_log[k-1] + 1) % NP));

    // long downstream backpressure must never trigger an abort
    set_knobs(4'b1111, 4, 100, 100, 0, 0, 1'b0);
    repeat (10) run_cycle();
    rdy_pct = 0;
    p0 = n_pulse;
    repeat (2000) run_cycle();
    chk("no_abort_on_backpressure", 64'(n_pulse - p0), 64'(0));
    chk("busy_held", 64'(bus.busy), 64'(1));
    rdy_pct = 100;
    repeat (20) run_cycle();

    // random traffic with source stalls long enough to time out, and stray beats
    set_knobs(4'b1111, 0, 70, 70, 10, 10, 1'b0);
    p0 = n_pulse;
    repeat (3000) run_cycle();
    chk("aborts_seen", 64'(n_pulse > p0), 64'(1));
    chk("drops_seen",  64'(bus.drop_count > 0), 64'(1));

    // asynchronous reset in the middle of a packet
    set_knobs(4'b1111, 4, 100, 100, 0, 0, 1'b0);
    n = 0;
    while (n < 500 && m_mode != 1) begin
      run_cycle();
      n++;
    end
    chk("busy_before_reset", 64'(bus.busy), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    exp_r = bus.src_valid & ~bus.src_startofpacket;
    chk("arst_out_valid",   64'(bus.out_valid),   64'(0));
    chk("arst_busy",        64'(bus.busy),        64'(0));
    chk("arst_src_ready",   64'(bus.src_ready),   64'(exp_r));
    chk("arst_drop_count",  64'(bus.drop_count),  64'(0));
    chk("arst_out_channel", 64'(bus.out_channel), 64'(0));
    driver_clear();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    set_knobs(4'b1111, 1, 100, 100, 0, 0, 1'b0);
    grant_log.delete();
    repeat (10) run_cycle();
    chk("grant_after_reset", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));

    // stray-only traffic from every port until the drop counter pins at its maximum
    set_knobs(4'b1111, 0, 100, 100, 0, 0, 1'b1);
    n = 0;
    while (n < 30000 && m_drops != 65535) begin
      run_cycle();
      n++;
    end
    repeat (10) run_cycle();
    chk("drop_saturated", 64'(bus.drop_count), 64'(16'hFFFF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
